// File: rtl/rename_reg_file_pkg.sv
// Shared types for the rename register file: the common-data-bus entry and index/tag widths.
package rename_reg_file_pkg;

    localparam int REG_WIDTH = 4;
    localparam int ROB_WIDTH = 4;
    localparam int DATA_W    = 32;

    typedef struct packed {
        logic                 valid;
        logic [ROB_WIDTH-1:0] tag;
        logic [DATA_W-1:0]    data;
    } cdb_t;

endpackage

// File: rtl/rename_reg_file_if.sv
// Issue/commit/read bundle between decode, ROB and the rename register file.
interface rename_reg_file_if
    import rename_reg_file_pkg::*;
#(
    parameter int N_READ   = 2,
    parameter int N_COMMIT = 1
);
    logic [N_READ-1:0][REG_WIDTH-1:0]   read_reg;
    cdb_t [N_READ-1:0]                  read;
    logic                               issue;
    logic [REG_WIDTH-1:0]               issue_reg;
    logic [ROB_WIDTH-1:0]               issue_tag;
    logic [N_COMMIT-1:0]                commit;
    logic [N_COMMIT-1:0][ROB_WIDTH-1:0] commit_tag;
    logic [N_COMMIT-1:0][DATA_W-1:0]    commit_data;
    logic                               flush;

    modport master (
        output read_reg, issue, issue_reg, issue_tag,
               commit, commit_tag, commit_data, flush,
        input  read
    );

    modport slave (
        input  read_reg, issue, issue_reg, issue_tag,
               commit, commit_tag, commit_data, flush,
        output read
    );
endinterface

// File: rtl/rename_reg_file_entry.sv
// One architectural register: value plus rename tag, updated by issue, commit and flush.
module rename_reg_entry
    import rename_reg_file_pkg::*;
#(
    parameter int N_COMMIT = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               issue_hit_i,
    input  logic [ROB_WIDTH-1:0]               issue_tag_i,
    input  logic [N_COMMIT-1:0]                commit_i,
    input  logic [N_COMMIT-1:0][ROB_WIDTH-1:0] commit_tag_i,
    input  logic [N_COMMIT-1:0][DATA_W-1:0]    commit_data_i,
    input  logic                               flush_i,
    output cdb_t                               entry_o
);

    cdb_t entry_q;
    cdb_t entry_d;

    always_comb begin
        entry_d = entry_q;
        // Descending scan so the lowest matching port is applied last and wins.
        for (int k = N_COMMIT - 1; k >= 0; k--) begin
            if (commit_i[k] && !entry_q.valid && (entry_q.tag == commit_tag_i[k])) begin
                entry_d.valid = 1'b1;
                entry_d.data  = commit_data_i[k];
            end
        end
        if (flush_i) begin
            entry_d.valid = 1'b1;
        end else if (issue_hit_i) begin
            entry_d.valid = 1'b0;
            entry_d.tag   = issue_tag_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            entry_q <= '{valid: 1'b1, tag: '0, data: '0};
        end else begin
            entry_q <= entry_d;
        end
    end

    assign entry_o = entry_q;

endmodule

// File: rtl/rename_reg_file.sv
// Rename register file: per-register entries, issue decode and combinational read muxes.
// Optional COMMIT_BYPASS_EN forwards same-cycle commits onto pending reads.
module rename_reg_file
    import rename_reg_file_pkg::*;
#(
    parameter int N_READ   = 2,
    parameter int N_COMMIT = 1
) (
    input logic               clk,
    input logic               reset,
    rename_reg_file_if.slave  bus
);

    localparam int N_REGS = 2 ** REG_WIDTH;

    cdb_t               entries [N_REGS];
    logic [N_REGS-1:0]  issue_hit;
    cdb_t [N_READ-1:0]  rd;

    for (genvar r = 0; r < N_REGS; r++) begin : g_reg
        assign issue_hit[r] = bus.issue && (bus.issue_reg == REG_WIDTH'(r));

        rename_reg_entry #(
            .N_COMMIT (N_COMMIT)
        ) u_entry (
            .clk           (clk),
            .reset         (reset),
            .issue_hit_i   (issue_hit[r]),
            .issue_tag_i   (bus.issue_tag),
            .commit_i      (bus.commit),
            .commit_tag_i  (bus.commit_tag),
            .commit_data_i (bus.commit_data),
            .flush_i       (bus.flush),
            .entry_o       (entries[r])
        );
    end

    always_comb begin
        for (int p = 0; p < N_READ; p++) begin
            rd[p] = entries[bus.read_reg[p]];
`ifdef COMMIT_BYPASS_EN
            if (!entries[bus.read_reg[p]].valid) begin
                for (int k = N_COMMIT - 1; k >= 0; k--) begin
                    if (bus.commit[k] && (entries[bus.read_reg[p]].tag == bus.commit_tag[k])) begin
                        rd[p].valid = 1'b1;
                        rd[p].data  = bus.commit_data[k];
                    end
                end
            end
`endif
        end
    end

    assign bus.read = rd;

endmodule

// File: tb/tb_rename_reg_file.sv
// Directed bench for rename_reg_file with two read and two commit ports.
module tb_rename_reg_file;
    import rename_reg_file_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    rename_reg_file_if #(.N_READ(2), .N_COMMIT(2)) rif ();

    rename_reg_file #(
        .N_READ   (2),
        .N_COMMIT (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (rif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic cdb_t mk(input logic v, input logic [ROB_WIDTH-1:0] t, input logic [DATA_W-1:0] d);
        mk = '{valid: v, tag: t, data: d};
    endfunction

    task automatic idle();
        rif.issue       = 1'b0;
        rif.issue_reg   = '0;
        rif.issue_tag   = '0;
        rif.commit      = '0;
        rif.commit_tag  = '0;
        rif.commit_data = '0;
        rif.flush       = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_issue(input logic [REG_WIDTH-1:0] r, input logic [ROB_WIDTH-1:0] t);
        idle();
        rif.issue     = 1'b1;
        rif.issue_reg = r;
        rif.issue_tag = t;
        cyc();
        idle();
    endtask

    task automatic test_reset();
        idle();
        rif.read_reg = '0;
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        rif.read_reg[0] = 4'd5;
        rif.read_reg[1] = 4'd5;
        #1;
        n_checks++;
        if (rif.read[0] !== mk(1'b1, 4'd0, 32'h0)) begin
            n_fail++;
            $display("FAIL reset_p0: got %h expected %h", rif.read[0], mk(1'b1, 4'd0, 32'h0));
        end
        n_checks++;
        if (rif.read[1] !== mk(1'b1, 4'd0, 32'h0)) begin
            n_fail++;
            $display("FAIL reset_p1: got %h expected %h", rif.read[1], mk(1'b1, 4'd0, 32'h0));
        end
    endtask

    task automatic test_issue_commit();
        do_issue(4'd3, 4'd7);
        rif.read_reg[0] = 4'd3;
        #1;
        n_checks++;
        if (rif.read[0] !== mk(1'b0, 4'd7, 32'h0)) begin
            n_fail++;
            $display("FAIL issue_r3: got %h expected %h", rif.read[0], mk(1'b0, 4'd7, 32'h0));
        end
        rif.commit[0]      = 1'b1;
        rif.commit_tag[0]  = 4'd7;
        rif.commit_data[0] = 32'hDEADBEEF;
        cyc();
        idle();
        #1;
        n_checks++;
        if (rif.read[0] !== mk(1'b1, 4'd7, 32'hDEADBEEF)) begin
            n_fail++;
            $display("FAIL commit_r3: got %h expected %h", rif.read[0], mk(1'b1, 4'd7, 32'hDEADBEEF));
        end
    endtask

    task automatic test_issue_commit_same_cycle();
        do_issue(4'd4, 4'd2);
        rif.issue          = 1'b1;
        rif.issue_reg      = 4'd4;
        rif.issue_tag      = 4'd9;
        rif.commit[0]      = 1'b1;
        rif.commit_tag[0]  = 4'd2;
        rif.commit_data[0] = 32'h55;
        cyc();
        idle();
        rif.read_reg[1] = 4'd4;
        #1;
        n_checks++;
        if (rif.read[1] !== mk(1'b0, 4'd9, 32'h55)) begin
            n_fail++;
            $display("FAIL issue_wins_r4: got %h expected %h", rif.read[1], mk(1'b0, 4'd9, 32'h55));
        end
    endtask

    task automatic test_flush();
        do_issue(4'd1, 4'd3);
        do_issue(4'd2, 4'd4);
        rif.flush          = 1'b1;
        rif.commit[0]      = 1'b1;
        rif.commit_tag[0]  = 4'd3;
        rif.commit_data[0] = 32'h11;
        rif.issue          = 1'b1;
        rif.issue_reg      = 4'd6;
        rif.issue_tag      = 4'd8;
        cyc();
        idle();
        rif.read_reg[0] = 4'd1;
        rif.read_reg[1] = 4'd2;
        #1;
        n_checks++;
        if (rif.read[0] !== mk(1'b1, 4'd3, 32'h11)) begin
            n_fail++;
            $display("FAIL flush_r1: got %h expected %h", rif.read[0], mk(1'b1, 4'd3, 32'h11));
        end
        n_checks++;
        if (rif.read[1] !== mk(1'b1, 4'd4, 32'h0)) begin
            n_fail++;
            $display("FAIL flush_r2: got %h expected %h", rif.read[1], mk(1'b1, 4'd4, 32'h0));
        end
        rif.read_reg[0] = 4'd6;
        #1;
        n_checks++;
        if (rif.read[0] !== mk(1'b1, 4'd0, 32'h0)) begin
            n_fail++;
            $display("FAIL flush_r6: got %h expected %h", rif.read[0], mk(1'b1, 4'd0, 32'h0));
        end
    endtask

    task automatic test_dual_commit();
        do_issue(4'd8, 4'd5);
        do_issue(4'd9, 4'd6);
        rif.commit         = 2'b11;
        rif.commit_tag[0]  = 4'd5;
        rif.commit_tag[1]  = 4'd6;
        rif.commit_data[0] = 32'hA;
        rif.commit_data[1] = 32'hB;
        cyc();
        idle();
        rif.read_reg[0] = 4'd8;
        rif.read_reg[1] = 4'd9;
        #1;
        n_checks++;
        if (rif.read[0] !== mk(1'b1, 4'd5, 32'hA)) begin
            n_fail++;
            $display("FAIL dual_r8: got %h expected %h", rif.read[0], mk(1'b1, 4'd5, 32'hA));
        end
        n_checks++;
        if (rif.read[1] !== mk(1'b1, 4'd6, 32'hB)) begin
            n_fail++;
            $display("FAIL dual_r9: got %h expected %h", rif.read[1], mk(1'b1, 4'd6, 32'hB));
        end
    endtask

    task automatic test_port_priority();
        do_issue(4'd10, 4'd1);
        rif.commit         = 2'b11;
        rif.commit_tag[0]  = 4'd1;
        rif.commit_tag[1]  = 4'd1;
        rif.commit_data[0] = 32'h100;
        rif.commit_data[1] = 32'h200;
        cyc();
        idle();
        rif.read_reg[0] = 4'd10;
        #1;
        n_checks++;
        if (rif.read[0] !== mk(1'b1, 4'd1, 32'h100)) begin
            n_fail++;
            $display("FAIL port_prio_r10: got %h expected %h", rif.read[0], mk(1'b1, 4'd1, 32'h100));
        end
    endtask

    task automatic test_stale_and_nomatch();
        // r3 is valid with tag 7; a retiring tag 7 must not touch it.
        rif.commit[1]      = 1'b1;
        rif.commit_tag[1]  = 4'd7;
        rif.commit_data[1] = 32'h99;
        cyc();
        idle();
        rif.read_reg[0] = 4'd3;
        rif.read_reg[1] = 4'd5;
        #1;
        n_checks++;
        if (rif.read[0] !== mk(1'b1, 4'd7, 32'hDEADBEEF)) begin
            n_fail++;
            $display("FAIL stale_r3: got %h expected %h", rif.read[0], mk(1'b1, 4'd7, 32'hDEADBEEF));
        end
        n_checks++;
        if (rif.read[1] !== mk(1'b1, 4'd0, 32'h0)) begin
            n_fail++;
            $display("FAIL nomatch_r5: got %h expected %h", rif.read[1], mk(1'b1, 4'd0, 32'h0));
        end
    endtask

    task automatic test_bypass();
        cdb_t exp_same;
        do_issue(4'd3, 4'd7);
        rif.commit[0]      = 1'b1;
        rif.commit_tag[0]  = 4'd7;
        rif.commit_data[0] = 32'h42;
        rif.read_reg[0]    = 4'd3;
        #1;
`ifdef COMMIT_BYPASS_EN
        exp_same = mk(1'b1, 4'd7, 32'h42);
`else
        exp_same = mk(1'b0, 4'd7, 32'hDEADBEEF);
`endif
        n_checks++;
        if (rif.read[0] !== exp_same) begin
            n_fail++;
            $display("FAIL bypass_same_cycle: got %h expected %h", rif.read[0], exp_same);
        end
        cyc();
        idle();
        #1;
        n_checks++;
        if (rif.read[0] !== mk(1'b1, 4'd7, 32'h42)) begin
            n_fail++;
            $display("FAIL bypass_next_cycle: got %h expected %h", rif.read[0], mk(1'b1, 4'd7, 32'h42));
        end
    endtask

    task automatic test_reset_midrun();
        do_issue(4'd7, 4'd3);
        reset         = 1'b1;
        rif.issue     = 1'b1;
        rif.issue_reg = 4'd7;
        rif.issue_tag = 4'd12;
        cyc();
        reset = 1'b0;
        idle();
        rif.read_reg[0] = 4'd7;
        rif.read_reg[1] = 4'd9;
        #1;
        n_checks++;
        if (rif.read[0] !== mk(1'b1, 4'd0, 32'h0)) begin
            n_fail++;
            $display("FAIL reset_mid_r7: got %h expected %h", rif.read[0], mk(1'b1, 4'd0, 32'h0));
        end
        n_checks++;
        if (rif.read[1] !== mk(1'b1, 4'd0, 32'h0)) begin
            n_fail++;
            $display("FAIL reset_mid_r9: got %h expected %h", rif.read[1], mk(1'b1, 4'd0, 32'h0));
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        idle();
        rif.read_reg = '0;
        test_reset();
        test_issue_commit();
        test_issue_commit_same_cycle();
        test_flush();
        test_dual_commit();
        test_port_priority();
        test_stale_and_nomatch();
        test_bypass();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
